// File: rtl/pipeline_stage_skid.sv
// pipeline_stage_skid: valid/ready inter-stage register with an optional 2-entry skid buffer,
// synchronous flush to a NOP bubble and a saturating back-pressure counter.
module pipeline_stage_skid #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               SKID      = 1,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count,
    output logic [CNT_W-1:0] bp_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_nxt;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_nxt;
    logic             in_fire;
    logic             out_fire;
    logic             stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign stall    = out_valid & ~out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath selection; flush overrides every handshake
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (!clr) begin
            state_nxt = EMPTY;
            main_nxt  = NOP_VALUE;
            skid_nxt  = NOP_VALUE;
        end else if (SKID != 0) begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = BUSY;
                        main_nxt  = in_data;
                    end
                end
                BUSY: begin
                    if (in_fire && !out_fire) begin
                        state_nxt = FULL;
                        skid_nxt  = in_data;
                    end else if (in_fire && out_fire) begin
                        main_nxt  = in_data;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                        main_nxt  = NOP_VALUE;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_nxt = BUSY;
                        main_nxt  = skid_q;
                        skid_nxt  = NOP_VALUE;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_nxt  = NOP_VALUE;
                    skid_nxt  = NOP_VALUE;
                end
            endcase
        end else begin
            if (in_fire) begin
                state_nxt = BUSY;
                main_nxt  = in_data;
            end else if (out_fire) begin
                state_nxt = EMPTY;
                main_nxt  = NOP_VALUE;
            end
        end
    end

    // Outputs: with the skid buffer in_ready is a pure state decode, cutting the ready path
    always_comb begin
        out_valid = (state != EMPTY);
        if (SKID != 0) begin
            in_ready = (state != FULL);
        end else begin
            in_ready = (state == EMPTY) | out_ready;
        end
        count    = state;
        out_data = main_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= NOP_VALUE;
            skid_q <= NOP_VALUE;
        end else begin
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    // Back-pressure counter keeps counting across flushes; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_cnt <= '0;
        end else if (stall) begin
            bp_cnt <= sat_inc(bp_cnt);
        end
    end

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Bench for pipeline_stage_skid: a queue-based model of both buffer variants checked every
// cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_pipeline_stage_skid;

    localparam logic [31:0] NOP1 = 32'h0000_0013;
    localparam logic [31:0] NOP0 = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s1_clr = 1'b1, s1_in_valid = 1'b0, s1_out_ready = 1'b0;
    logic [31:0] s1_in_data = '0;
    logic        s1_in_ready, s1_out_valid;
    logic [31:0] s1_out_data;
    logic [1:0]  s1_count;
    logic [2:0]  s1_bp;

    logic        s0_clr = 1'b1, s0_in_valid = 1'b0, s0_out_ready = 1'b0;
    logic [31:0] s0_in_data = '0;
    logic        s0_in_ready, s0_out_valid;
    logic [31:0] s0_out_data;
    logic [1:0]  s0_count;
    logic [15:0] s0_bp;

    pipeline_stage_skid #(.WIDTH(32), .NOP_VALUE(NOP1), .SKID(1), .CNT_W(3)) u_s1 (
        .clk(clk), .rst_n(rst_n), .clr(s1_clr),
        .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_data(s1_in_data),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_data(s1_out_data),
        .count(s1_count), .bp_cnt(s1_bp)
    );

    pipeline_stage_skid #(.WIDTH(32), .NOP_VALUE(NOP0), .SKID(0), .CNT_W(16)) u_s0 (
        .clk(clk), .rst_n(rst_n), .clr(s0_clr),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
        .count(s0_count), .bp_cnt(s0_bp)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: each stage is a bounded FIFO of held bundles
    logic [31:0] q1[$];
    logic [31:0] q0[$];
    int bp1 = 0;
    int bp0 = 0;
    bit m_fi, m_fo;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1.delete();
            q0.delete();
            bp1 = 0;
            bp0 = 0;
        end else begin
            m_fi = s1_in_valid && (q1.size() < 2);
            m_fo = (q1.size() != 0) && s1_out_ready;
            if (q1.size() != 0 && !s1_out_ready && bp1 < 7) bp1++;
            if (!s1_clr) q1.delete();
            else begin
                if (m_fo) void'(q1.pop_front());
                if (m_fi) q1.push_back(s1_in_data);
            end

            m_fi = s0_in_valid && (q0.size() == 0 || s0_out_ready);
            m_fo = (q0.size() != 0) && s0_out_ready;
            if (q0.size() != 0 && !s0_out_ready && bp0 < 65535) bp0++;
            if (!s0_clr) q0.delete();
            else begin
                if (m_fo) void'(q0.pop_front());
                if (m_fi) q0.push_back(s0_in_data);
            end
        end
    end

    always @(negedge clk) begin
        chk("s1 out_valid", 64'(s1_out_valid), 64'(q1.size() != 0));
        chk("s1 out_data", 64'(s1_out_data), 64'((q1.size() != 0) ? q1[0] : NOP1));
        chk("s1 count", 64'(s1_count), 64'(q1.size()));
        chk("s1 in_ready", 64'(s1_in_ready), 64'(q1.size() < 2));
        chk("s1 bp_cnt", 64'(s1_bp), 64'(bp1));
        chk("s0 out_valid", 64'(s0_out_valid), 64'(q0.size() != 0));
        chk("s0 out_data", 64'(s0_out_data), 64'((q0.size() != 0) ? q0[0] : NOP0));
        chk("s0 count", 64'(s0_count), 64'(q0.size()));
        chk("s0 in_ready", 64'(s0_in_ready), 64'(q0.size() == 0 || s0_out_ready));
        chk("s0 bp_cnt", 64'(s0_bp), 64'(bp0));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) cyc();
        chk("reset s1 out_valid", 64'(s1_out_valid), 64'd0);
        chk("reset s1 out_data", 64'(s1_out_data), 64'h13);
        chk("reset s1 count", 64'(s1_count), 64'd0);
        chk("reset s1 bp_cnt", 64'(s1_bp), 64'd0);
        chk("reset s1 in_ready", 64'(s1_in_ready), 64'd1);
        chk("reset s0 in_ready", 64'(s0_in_ready), 64'd1);
        chk("reset s0 out_data", 64'(s0_out_data), 64'hFFFF_FFFF);
        rst_n = 1'b1;
        cyc();

        // Streaming with out_ready held high
        s1_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s1_in_valid = 1'b1;
            s1_in_data  = 32'(i);
            cyc();
            chk("stream data", 64'(s1_out_data), 64'(i));
            chk("stream count", 64'(s1_count), 64'd1);
        end
        s1_in_valid = 1'b0;
        cyc();
        chk("stream drain count", 64'(s1_count), 64'd0);
        chk("stream drain data", 64'(s1_out_data), 64'h13);

        // Back-pressure fills the skid buffer, then drains in order
        s1_out_ready = 1'b0;
        s1_in_valid = 1'b1; s1_in_data = 32'hA; cyc();
        s1_in_data = 32'hB; cyc();
        s1_in_data = 32'hC; cyc();
        cyc();
        chk("bp head", 64'(s1_out_data), 64'hA);
        chk("bp count", 64'(s1_count), 64'd2);
        chk("bp in_ready", 64'(s1_in_ready), 64'd0);
        chk("bp model depth", 64'(q1.size()), 64'd2);
        s1_out_ready = 1'b1;
        cyc();
        chk("drain 2nd", 64'(s1_out_data), 64'hB);
        cyc();
        chk("drain 3rd", 64'(s1_out_data), 64'hC);
        s1_in_valid = 1'b0;
        cyc();
        chk("drain empty", 64'(s1_count), 64'd0);

        // Asynchronous reset while full
        s1_out_ready = 1'b0;
        s1_in_valid = 1'b1; s1_in_data = 32'hA; cyc();
        s1_in_data = 32'hB; cyc();
        s1_in_valid = 1'b0;
        chk("full before reset", 64'(s1_count), 64'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 64'(s1_out_valid), 64'd0);
        chk("async rst out_data", 64'(s1_out_data), 64'h13);
        chk("async rst count", 64'(s1_count), 64'd0);
        chk("async rst bp_cnt", 64'(s1_bp), 64'd0);
        #1 rst_n = 1'b1;
        cyc();

        // Saturating counter survives flush, cleared by reset
        s1_in_valid = 1'b1; s1_in_data = 32'h5; cyc();
        s1_in_valid = 1'b0;
        repeat (3) cyc();
        chk("bp partial", 64'(s1_bp), 64'd3);
        repeat (7) cyc();
        chk("bp saturated", 64'(s1_bp), 64'd7);
        chk("bp model sat", 64'(bp1), 64'd7);
        s1_clr = 1'b0; cyc(); s1_clr = 1'b1;
        chk("bp after flush", 64'(s1_bp), 64'd7);
        chk("flush empties", 64'(s1_count), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("bp after reset", 64'(s1_bp), 64'd0);
        #1 rst_n = 1'b1;
        cyc();

        // Flush while full with a concurrent handshake
        s1_out_ready = 1'b0;
        s1_in_valid = 1'b1; s1_in_data = 32'hA; cyc();
        s1_in_data = 32'hB; cyc();
        s1_in_data = 32'hC; s1_out_ready = 1'b1; s1_clr = 1'b0; cyc();
        chk("flush out_valid", 64'(s1_out_valid), 64'd0);
        chk("flush out_data", 64'(s1_out_data), 64'h13);
        chk("flush count", 64'(s1_count), 64'd0);
        s1_clr = 1'b1; s1_in_valid = 1'b0; cyc();
        chk("flush input dropped", 64'(s1_count), 64'd0);
        // Flush discards an input that would otherwise fire
        s1_out_ready = 1'b0;
        s1_in_valid = 1'b1; s1_in_data = 32'hD; cyc();
        s1_in_data = 32'hE; s1_clr = 1'b0; cyc();
        s1_clr = 1'b1; s1_in_valid = 1'b0; cyc();
        chk("flush busy dropped", 64'(s1_count), 64'd0);
        chk("flush busy data", 64'(s1_out_data), 64'h13);

        // Single-entry variant: combinational in_ready, replace without bubble
        s0_out_ready = 1'b0;
        s0_in_valid = 1'b1; s0_in_data = 32'h1111; cyc();
        chk("s0 load", 64'(s0_out_data), 64'h1111);
        chk("s0 stalled in_ready", 64'(s0_in_ready), 64'd0);
        s0_in_data = 32'h2222; s0_out_ready = 1'b1;
        #1;
        chk("s0 comb in_ready", 64'(s0_in_ready), 64'd1);
        cyc();
        chk("s0 replace data", 64'(s0_out_data), 64'h2222);
        chk("s0 replace count", 64'(s0_count), 64'd1);
        s0_out_ready = 1'b0;
        #1;
        chk("s0 in_ready low", 64'(s0_in_ready), 64'd0);
        s0_in_valid = 1'b0; s0_out_ready = 1'b1;
        cyc();
        chk("s0 drained", 64'(s0_count), 64'd0);
        chk("s0 drained data", 64'(s0_out_data), 64'hFFFF_FFFF);

        // Randomised traffic on both variants
        for (int k = 0; k < 600; k++) begin
            s1_in_valid  = ($urandom_range(0, 3) != 0);
            s1_in_data   = $urandom();
            s1_out_ready = ($urandom_range(0, 2) != 0);
            s1_clr       = ($urandom_range(0, 24) != 0);
            s0_in_valid  = ($urandom_range(0, 3) != 0);
            s0_in_data   = $urandom();
            s0_out_ready = ($urandom_range(0, 2) != 0);
            s0_clr       = ($urandom_range(0, 24) != 0);
            if (k == 300) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            cyc();
        end
        s1_in_valid = 1'b0; s0_in_valid = 1'b0;
        s1_clr = 1'b1; s0_clr = 1'b1;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
